// File: rtl/paraadd_res_collect.sv
// paraadd_res_collect
// Receive side of the 8-lane parallel adder array. Every result word is captured into
// a small FIFO and drained over a valid/ready interface. The adder array cannot be
// stalled, so issue credit (issue_ok) is granted only while every result already in
// flight, plus the one about to be issued, is guaranteed a FIFO slot.
// Sticky error flags record credit violations, overflow drops and results that arrive
// with nothing outstanding.

module paraadd_res_collect #(
    parameter int DATA_W  = 128,
    parameter int DEPTH   = 8,
    parameter int ADD_LAT = 2,
    localparam int CNT_W  = $clog2(DEPTH) + 1,
    localparam int PTR_W  = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              issue_v,
    output logic              issue_ok,
    input  logic [DATA_W-1:0] addres,
    input  logic              addres_v,
    output logic [DATA_W-1:0] out_data,
    output logic              out_v,
    input  logic              out_rdy,
    output logic [CNT_W-1:0]  occupancy,
    output logic [2:0]        err
);

    // A misconfigured instance never grants credit, so it fails safe rather than
    // silently corrupting pointer arithmetic.
    localparam bit PARAMS_OK = (DEPTH >= 2) && ((DEPTH & (DEPTH - 1)) == 0) && (ADD_LAT >= 1);

    logic [DATA_W-1:0] mem_r [DEPTH];
    logic [PTR_W-1:0]  wr_ptr_r;
    logic [PTR_W-1:0]  rd_ptr_r;
    logic [CNT_W-1:0]  occ_r;
    logic [CNT_W-1:0]  infl_r;
    logic [2:0]        err_r;
    logic              out_v_r;
    logic              issue_ok_r;

    logic              pop_s;
    logic              full_s;
    logic              push_s;
    logic              drop_s;
    logic              spur_s;
    logic              no_credit_s;
    logic [CNT_W-1:0]  occ_nxt_s;
    logic [CNT_W-1:0]  infl_nxt_s;
    logic [CNT_W:0]    committed_s;
    logic              credit_nxt_s;
    logic [2:0]        err_nxt_s;

    // Next-state decode: push/pop qualification, counters, credit and error flags.
    always_comb begin
        pop_s        = out_v_r & out_rdy;
        full_s       = (occ_r == CNT_W'(DEPTH));
        push_s       = addres_v & (~full_s | pop_s);
        drop_s       = addres_v & full_s & ~pop_s;
        spur_s       = addres_v & ~issue_v & (infl_r == {CNT_W{1'b0}});
        no_credit_s  = issue_v & ~issue_ok_r;
        occ_nxt_s    = occ_r;
        infl_nxt_s   = infl_r;

        case ({push_s, pop_s})
            2'b10:   occ_nxt_s = occ_r + CNT_W'(1);
            2'b01:   occ_nxt_s = occ_r - CNT_W'(1);
            default: occ_nxt_s = occ_r;
        endcase

        // Issue and result in the same cycle cancel; the counter saturates high and
        // floors at zero so a stray result cannot wrap it into a huge value.
        case ({issue_v, addres_v})
            2'b10:   infl_nxt_s = (infl_r == {CNT_W{1'b1}}) ? infl_r : infl_r + CNT_W'(1);
            2'b01:   infl_nxt_s = (infl_r == {CNT_W{1'b0}}) ? infl_r : infl_r - CNT_W'(1);
            default: infl_nxt_s = infl_r;
        endcase

        committed_s  = {1'b0, occ_nxt_s} + {1'b0, infl_nxt_s};
        credit_nxt_s = PARAMS_OK && (committed_s < (CNT_W + 1)'(DEPTH));
        err_nxt_s    = err_r | {spur_s, drop_s, no_credit_s};
    end

    // Control state: pointers, occupancy, in-flight count, sticky errors, registered flags.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr_r   <= {PTR_W{1'b0}};
            rd_ptr_r   <= {PTR_W{1'b0}};
            occ_r      <= {CNT_W{1'b0}};
            infl_r     <= {CNT_W{1'b0}};
            err_r      <= 3'b000;
            out_v_r    <= 1'b0;
            issue_ok_r <= 1'b0;
        end else begin
            wr_ptr_r   <= push_s ? wr_ptr_r + PTR_W'(1) : wr_ptr_r;
            rd_ptr_r   <= pop_s  ? rd_ptr_r + PTR_W'(1) : rd_ptr_r;
            occ_r      <= occ_nxt_s;
            infl_r     <= infl_nxt_s;
            err_r      <= err_nxt_s;
            out_v_r    <= (occ_nxt_s != {CNT_W{1'b0}});
            issue_ok_r <= credit_nxt_s;
        end
    end

    // Result storage; contents are don't-care until written, so no reset.
    always_ff @(posedge clk) begin
        if (push_s) begin
            mem_r[wr_ptr_r] <= addres;
        end
    end

    assign out_v     = out_v_r;
    assign out_data  = out_v_r ? mem_r[rd_ptr_r] : {DATA_W{1'b0}};
    assign occupancy = occ_r;
    assign issue_ok  = issue_ok_r;
    assign err       = err_r;

endmodule

// File: tb/tb_paraadd_res_collect.sv
// Bench for paraadd_res_collect: a behavioural adder pipeline feeds results, a negedge
// scoreboard queues accepted words and checks every popped word in order, a table of
// issue/pop phases checks credit and occupancy, and hand-written sequences cover the
// full-FIFO, drop, credit-violation, spurious-result and mid-operation reset cases.

module tb_paraadd_res_collect;

    localparam int DATA_W  = 128;
    localparam int DEPTH   = 8;
    localparam int ADD_LAT = 2;
    localparam int CNT_W   = $clog2(DEPTH) + 1;

    logic              clk      = 1'b0;
    logic              rst      = 1'b1;
    logic              issue_v  = 1'b0;
    logic              issue_ok;
    logic [DATA_W-1:0] addres;
    logic              addres_v;
    logic [DATA_W-1:0] out_data;
    logic              out_v;
    logic              out_rdy  = 1'b0;
    logic [CNT_W-1:0]  occupancy;
    logic [2:0]        err;

    logic [DATA_W-1:0] iss_data   = '0;
    logic              force_v    = 1'b0;
    logic [DATA_W-1:0] force_data = '0;

    logic [ADD_LAT-1:0] pipe_v;
    logic [DATA_W-1:0]  pipe_d [ADD_LAT];

    int n_tests = 0;
    int n_fail  = 0;

    logic [DATA_W-1:0] sb_q [$];
    int                m_occ = 0;

    typedef struct {
        int         n_try;
        int         exp_iss;
        int         n_pop;
        int         exp_occ;
        logic       exp_ok;
        logic [2:0] exp_err;
    } row_t;

    always #5 clk = ~clk;

    paraadd_res_collect #(.DATA_W(DATA_W), .DEPTH(DEPTH), .ADD_LAT(ADD_LAT)) dut (
        .clk       (clk),
        .rst       (rst),
        .issue_v   (issue_v),
        .issue_ok  (issue_ok),
        .addres    (addres),
        .addres_v  (addres_v),
        .out_data  (out_data),
        .out_v     (out_v),
        .out_rdy   (out_rdy),
        .occupancy (occupancy),
        .err       (err)
    );

    // Behavioural adder array: the issued operand tag emerges ADD_LAT cycles later.
    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            pipe_v <= '0;
        end else begin
            pipe_v    <= {pipe_v[ADD_LAT-2:0], issue_v};
            pipe_d[0] <= iss_data;
            for (int i = 1; i < ADD_LAT; i++) pipe_d[i] <= pipe_d[i-1];
        end
    end

    assign addres_v = pipe_v[ADD_LAT-1] | force_v;
    assign addres   = force_v ? force_data : pipe_d[ADD_LAT-1];

    task automatic chk(input string name, input logic [DATA_W-1:0] act, input logic [DATA_W-1:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic issue_try(input int n_try, output int issued);
        issued = 0;
        for (int i = 0; i < n_try; i++) begin
            issue_v  = issue_ok;
            iss_data = {$urandom(), $urandom(), $urandom(), $urandom()};
            if (issue_ok) issued++;
            step();
        end
        issue_v = 1'b0;
    endtask

    task automatic pop_n(input int n);
        for (int i = 0; i < n; i++) begin
            out_rdy = 1'b1;
            step();
        end
        out_rdy = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b0;
        #1;
        chk("rst_out_v", out_v, 1'b0);
        chk("rst_out_data", out_data, '0);
        chk("rst_occ", occupancy, '0);
        chk("rst_err", err, 3'b000);
        chk("rst_issue_ok", issue_ok, 1'b0);
        step();
        step();
        rst = 1'b1;
        step();
        chk("post_rst_issue_ok", issue_ok, 1'b1);
    endtask

    // Scoreboard: model the FIFO from the interface, queue accepted words, check pops.
    initial begin
        logic pop_m;
        logic push_m;
        forever begin
            @(negedge clk);
            if (!rst) begin
                sb_q.delete();
                m_occ = 0;
            end else begin
                chk("out_v_track", out_v, (m_occ != 0));
                pop_m = (m_occ != 0) && out_rdy;
                if (pop_m) begin
                    chk("pop_data", out_data, sb_q[0]);
                    void'(sb_q.pop_front());
                end
                push_m = addres_v && ((m_occ != DEPTH) || pop_m);
                if (push_m) sb_q.push_back(addres);
                m_occ = m_occ + (push_m ? 1 : 0) - (pop_m ? 1 : 0);
            end
        end
    end

    initial begin
        row_t              rows [6];
        int                iss;
        logic [DATA_W-1:0] pat;

        rows[0] = '{3,  3, 0, 3, 1'b1, 3'b000};
        rows[1] = '{10, 5, 0, 8, 1'b0, 3'b000};
        rows[2] = '{0,  0, 2, 6, 1'b1, 3'b000};
        rows[3] = '{6,  2, 0, 8, 1'b0, 3'b000};
        rows[4] = '{0,  0, 8, 0, 1'b1, 3'b000};
        rows[5] = '{4,  4, 4, 0, 1'b1, 3'b000};

        do_reset();

        // Single issue: result at +2, visible at the output one cycle after capture.
        pat      = {16'h0008, 16'h0007, 16'h0006, 16'h0005, 16'h0004, 16'h0003, 16'h0002, 16'h0001};
        issue_v  = 1'b1;
        iss_data = pat;
        step();
        issue_v  = 1'b0;
        chk("t1_out_v_p1", out_v, 1'b0);
        step();
        chk("t1_out_v_p2", out_v, 1'b0);
        step();
        chk("t1_out_v_p3", out_v, 1'b1);
        chk("t1_out_data", out_data, pat);
        chk("t1_err", err, 3'b000);
        step();
        chk("t1_hold_data", out_data, pat);
        pop_n(1);
        step();
        chk("t1_empty", out_v, 1'b0);

        // Table of issue/pop phases.
        for (int r = 0; r < 6; r++) begin
            issue_try(rows[r].n_try, iss);
            repeat (ADD_LAT + 2) step();
            pop_n(rows[r].n_pop);
            step();
            chk($sformatf("row%0d_issued", r), iss, rows[r].exp_iss);
            chk($sformatf("row%0d_occ", r), occupancy, rows[r].exp_occ);
            chk($sformatf("row%0d_issue_ok", r), issue_ok, rows[r].exp_ok);
            chk($sformatf("row%0d_err", r), err, rows[r].exp_err);
        end

        // Full FIFO with a pop and a result in the same cycle: accepted, no drop.
        issue_try(12, iss);
        chk("t3_issued", iss, 8);
        repeat (ADD_LAT + 2) step();
        chk("t3_full", occupancy, 8);
        force_v    = 1'b1;
        force_data = {4{32'hC0DE_5A5A}};
        out_rdy    = 1'b1;
        step();
        force_v = 1'b0;
        out_rdy = 1'b0;
        chk("t3_occ_same", occupancy, 8);
        chk("t3_err_spur", err, 3'b100);
        pop_n(8);
        step();
        chk("t3_drained", occupancy, 0);

        // Full FIFO, no pop: word dropped; then issue without credit.
        issue_try(12, iss);
        chk("t4_issued", iss, 8);
        repeat (ADD_LAT + 2) step();
        force_v    = 1'b1;
        force_data = {4{32'hDEAD_BEEF}};
        step();
        force_v = 1'b0;
        chk("t4_occ", occupancy, 8);
        chk("t4_err_drop", err, 3'b110);
        chk("t4_no_credit", issue_ok, 1'b0);
        issue_v = 1'b1;
        step();
        issue_v = 1'b0;
        chk("t4_err_issue", err, 3'b111);
        repeat (ADD_LAT + 2) step();
        chk("t4_occ_after", occupancy, 8);

        // Spurious result on an idle block: flagged, stored, in-flight count untouched.
        do_reset();
        force_v    = 1'b1;
        force_data = {4{32'h1234_5678}};
        step();
        force_v = 1'b0;
        chk("t5_err", err, 3'b100);
        chk("t5_occ", occupancy, 1);
        issue_try(10, iss);
        chk("t5_credit", iss, 7);
        repeat (ADD_LAT + 2) step();
        chk("t5_full", occupancy, 8);
        chk("t5_err_final", err, 3'b100);

        // Reset mid-operation with 5 stored and 2 in flight.
        do_reset();
        issue_try(5, iss);
        repeat (ADD_LAT + 2) step();
        chk("t6_occ5", occupancy, 5);
        issue_v  = 1'b1;
        iss_data = {4{32'hAAAA_5555}};
        step();
        iss_data = {4{32'h5555_AAAA}};
        step();
        issue_v = 1'b0;
        chk("t6_pre_ok", issue_ok, 1'b1);
        rst = 1'b0;
        #1;
        chk("t6_out_v", out_v, 1'b0);
        chk("t6_occ", occupancy, 0);
        chk("t6_err", err, 3'b000);
        chk("t6_issue_ok", issue_ok, 1'b0);
        step();
        step();
        rst = 1'b1;
        step();
        chk("t6_ok_after", issue_ok, 1'b1);
        repeat (ADD_LAT + 2) step();
        chk("t6_err_after", err, 3'b000);
        chk("t6_occ_after", occupancy, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
